ram_loader: RTL

Program loader that fills the 16×8 main memory from a byte-stream source before the CPU runs. It sits directly upstream of the RAM: it owns the RAM address, the write strobe, and the shared 8-bit bus during a load, and holds the CPU in halt until the image is complete. An optional read-back pass checks the loaded image with a checksum.

---
 rtl/ram_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ram_loader.sv
// ram_loader: fills a 2^ADDR_W x DATA_W RAM from a valid/ready byte stream while holding the CPU halted.
// Define RAM_LOADER_VERIFY_EN to add a read-back checksum pass before completion.
module ram_loader #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int LOAD_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  inout  wire  [DATA_W-1:0] bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_enable,
  output logic              ram_write,
  output logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_LEN - 1);

`ifdef RAM_LOADER_VERIFY_EN
  typedef enum logic [2:0] {IDLE, WAIT_BYTE, WRITE, VERIFY, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT_BYTE, WRITE, DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] sum_q;
`ifdef RAM_LOADER_VERIFY_EN
  logic [DATA_W-1:0] chk_q;
  logic              cmp_q;
  logic              err_q;
`endif

  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = WAIT_BYTE;
      WAIT_BYTE: if (in_valid) state_d = WRITE;
      WRITE: begin
        if (addr_q != LAST_ADDR) state_d = WAIT_BYTE;
`ifdef RAM_LOADER_VERIFY_EN
        else state_d = VERIFY;
`else
        else state_d = DONE;
`endif
      end
`ifdef RAM_LOADER_VERIFY_EN
      VERIFY:    if (cmp_q) state_d = DONE;
`endif
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Control registers: state, address and verify bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
`ifdef RAM_LOADER_VERIFY_EN
      cmp_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          addr_q <= '0;
`ifdef RAM_LOADER_VERIFY_EN
          cmp_q  <= 1'b0;
          err_q  <= 1'b0;
`endif
        end
        WRITE: addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
`ifdef RAM_LOADER_VERIFY_EN
        VERIFY: begin
          if (cmp_q) begin
            cmp_q <= 1'b0;
            err_q <= (chk_q != sum_q);
          end else if (addr_q == LAST_ADDR) begin
            addr_q <= '0;
            cmp_q  <= 1'b1;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Data registers: captured byte and running checksums, cleared on start rather than reset
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: if (start) begin
        sum_q <= '0;
`ifdef RAM_LOADER_VERIFY_EN
        chk_q <= '0;
`endif
      end
      WAIT_BYTE: if (in_valid) data_q <= in_data;
      WRITE:     sum_q <= wrap_add(sum_q, data_q);
`ifdef RAM_LOADER_VERIFY_EN
      VERIFY:    if (!cmp_q) chk_q <= wrap_add(chk_q, bus);
`endif
      default: ;
    endcase
  end

  assign in_ready  = (state_q == WAIT_BYTE);
  assign ram_write = (state_q == WRITE);
  assign bus       = ram_write ? data_q : {DATA_W{1'bz}};
  assign ram_addr  = addr_q;
  assign busy      = (state_q != IDLE);
  assign cpu_halt  = (state_q != IDLE);
  assign done      = (state_q == DONE);
`ifdef RAM_LOADER_VERIFY_EN
  assign ram_enable = (state_q == VERIFY) && !cmp_q;
  assign error      = err_q;
`else
  assign ram_enable = 1'b0;
  assign error      = 1'b0;
`endif

endmodule
